// File: rtl/rrspsram_pkg.sv
// Shared definitions for the rrspsram_lat_be single-port SRAM.
//   state_e          : controller state (CLEAR = zero-fill sweep, RUN = serving requests)
//   LAT_MIN/LAT_MAX  : legal bounds of the read latency parameter
package rrspsram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

endpackage

// File: rtl/rrspsram_lat_be_rd_pipe.sv
// sram_rd_pipe: read-latency extension behind the array output register.
// STAGES data+valid stages; a stage only loads data when its incoming valid
// is set, so the last stage (the DO register) holds between results.
//   clk, rst     : clock, synchronous active-high reset (clears data and valids)
//   in_data/vld  : result from the array output register
//   out_data/vld : delayed result (DO / DO_VALID)
module sram_rd_pipe
    import rrspsram_pkg::*;
#(
    parameter int DW     = 16,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    output logic [DW-1:0] out_data,
    output logic          out_vld
);

    if (STAGES < 1 || STAGES > LAT_MAX - 1) begin : g_bad_stages
        $error("sram_rd_pipe: STAGES out of range");
    end

    logic [STAGES-1:0]         vld_pipe_q, vld_pipe_d;
    logic [STAGES-1:0][DW-1:0] dat_q, dat_d;

    // Stage i is fed from entry i of these; entry 0 is the pipe input.
    logic [STAGES:0]           v_in;
    logic [STAGES:0][DW-1:0]   d_in;

    assign v_in = {vld_pipe_q, in_vld};
    assign d_in = {dat_q, in_data};

    always_comb begin
        vld_pipe_d = '0;
        dat_d      = dat_q;
        for (int i = 0; i < STAGES; i++) begin
            vld_pipe_d[i] = v_in[i];
            if (v_in[i]) dat_d[i] = d_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            dat_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_q      <= dat_d;
        end
    end

    assign out_data = dat_q[STAGES-1];
    assign out_vld  = vld_pipe_q[STAGES-1];

endmodule

// File: rtl/rrspsram_lat_be.sv
// rrspsram_lat_be: single-port SRAM with per-byte write enables, configurable
// read latency (1..4) and an optional zero-fill sweep after reset.
//   CLK, RST   : clock, synchronous active-high reset
//   A, DI, BE  : word address, write data, per-granule write enables
//   ENABLE, WE : request strobe, 1 = write / 0 = read
//   READY      : requests accepted (controller in RUN)
//   DO         : read data, holds until the next result
//   DO_VALID   : one-cycle pulse per completed read
module rrspsram_lat_be
    import rrspsram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [ADDR_WIDTH-1:0]            A,
    input  logic [DATA_WIDTH-1:0]            DI,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] BE,
    input  logic                             ENABLE,
    input  logic                             WE,
    output logic                             READY,
    output logic [DATA_WIDTH-1:0]            DO,
    output logic                             DO_VALID
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_be
        $error("rrspsram_lat_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
        $error("rrspsram_lat_be: LATENCY out of range");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  rd_vld_q, rd_vld_d;

    logic                  accept;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NBE-1:0]        mem_be;

    assign READY  = (state_q == ST_RUN);
    assign accept = ENABLE && READY && !RST;

    // The clear sweep and user writes share the single write port; the sweep
    // owns it for its whole duration since no request is accepted then.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = A;
        mem_wdata = DI;
        mem_be    = BE;
        rd_d      = rd_q;
        rd_vld_d  = 1'b0;
        if (state_q == ST_CLEAR) begin
            mem_we    = !RST;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
            cnt_d     = cnt_q + 1'b1;   // wraps back to 0 on the last word
            if (&cnt_q) state_d = ST_RUN;
        end else if (accept) begin
            if (WE) begin
                mem_we = 1'b1;
            end else begin
                rd_d     = mem[A];
                rd_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Memory has no reset: contents survive RST unless the sweep clears them.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < NBE; i++) begin
                if (mem_be[i]) mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // The array output register supplies one cycle of latency; the rest
    // comes from the pipe.
    if (LATENCY > 1) begin : g_pipe
        sram_rd_pipe #(
            .DW     (DATA_WIDTH),
            .STAGES (LATENCY - 1)
        ) u_rd_pipe (
            .clk      (CLK),
            .rst      (RST),
            .in_data  (rd_q),
            .in_vld   (rd_vld_q),
            .out_data (DO),
            .out_vld  (DO_VALID)
        );
    end else begin : g_direct
        assign DO       = rd_q;
        assign DO_VALID = rd_vld_q;
    end

endmodule

// File: tb/tb_rrspsram_lat_be.sv
// Scoreboard bench for rrspsram_lat_be: five instances with different
// LATENCY / CLEAR_ON_RESET settings, exercised one at a time with directed
// vectors. Reads push {instance, data, due cycle}; a monitor pops on DO_VALID.
module tb_rrspsram_lat_be;

    localparam int NDUT = 5;
    localparam int LAT_T [NDUT] = '{1, 3, 2, 4, 1};
    localparam int COR_T [NDUT] = '{1, 1, 1, 1, 0};

    typedef struct {
        int          k;
        logic [15:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NDUT-1:0]       rst, en, we, ready, dvld;
    logic [NDUT-1:0][3:0]  a;
    logic [NDUT-1:0][15:0] di, dout;
    logic [NDUT-1:0][1:0]  be;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        rrspsram_lat_be #(
            .ADDR_WIDTH     (4),
            .DATA_WIDTH     (16),
            .BYTE_WIDTH     (8),
            .LATENCY        (LAT_T[g]),
            .CLEAR_ON_RESET (COR_T[g])
        ) u_dut (
            .CLK      (clk),
            .RST      (rst[g]),
            .A        (a[g]),
            .DI       (di[g]),
            .BE       (be[g]),
            .ENABLE   (en[g]),
            .WE       (we[g]),
            .READY    (ready[g]),
            .DO       (dout[g]),
            .DO_VALID (dvld[g])
        );
    end

    exp_t sbq [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [3:0] ad, input logic [15:0] d, input logic [1:0] b);
        en[k] = 1'b1; we[k] = 1'b1; a[k] = ad; di[k] = d; be[k] = b;
        step();
        en[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic rd(input int k, input logic [3:0] ad, input logic [15:0] exp_d);
        exp_t e;
        en[k] = 1'b1; we[k] = 1'b0; a[k] = ad;
        e.k = k; e.d = exp_d; e.due = cyc + LAT_T[k];
        sbq.push_back(e);
        step();
        en[k] = 1'b0;
    endtask

    task automatic count_clear(input int k, input string nm);
        int n;
        n = 0;
        while (!ready[k] && n < 40) begin
            step();
            n++;
        end
        chk(nm, n, 16);
    endtask

    // Monitor: every DO_VALID must match the oldest outstanding read.
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (dvld[k] !== 1'b0) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid dut%0d: DO_VALID=%b DO=%h, required no result", k, dvld[k], dout[k]);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("sb_inst dut%0d", k), k, e.k);
                    chk($sformatf("sb_data dut%0d", k), dout[k], e.d);
                    chk($sformatf("sb_cycle dut%0d", k), cyc, e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = '1; en = '0; we = '0; a = '0; di = '0; be = '0;
        repeat (2) step();

        // reset state of every instance
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst_ready dut%0d", k), ready[k], (COR_T[k] == 0));
            chk($sformatf("rst_do dut%0d", k), dout[k], 0);
            chk($sformatf("rst_dovalid dut%0d", k), dvld[k], 0);
        end
        rst = '0;
        chk("nofill_ready_first", ready[4], 1);

        // clear length; requests near the end of the sweep must be ignored
        n = 0;
        while (!ready[0] && n < 40) begin
            if (n == 15) begin
                en[2] = 1'b1; we[2] = 1'b1; a[2] = 4'd0; di[2] = 16'hFFFF; be[2] = 2'b11;
                en[1] = 1'b1; we[1] = 1'b0; a[1] = 4'd0;
            end
            step();
            en[2] = 1'b0; we[2] = 1'b0; en[1] = 1'b0;
            n++;
        end
        chk("clear_len", n, 16);

        // all addresses zero after the sweep
        for (int i = 0; i < 16; i++) rd(0, 4'(i), 16'h0000);
        repeat (3) step();

        // byte-enable merge, read right after write, BE=00 no-op
        wr(0, 4'd2, 16'h1234, 2'b11);
        wr(0, 4'd2, 16'hAB00, 2'b10);
        rd(0, 4'd2, 16'hAB34);
        wr(0, 4'd2, 16'hFFFF, 2'b00);
        rd(0, 4'd2, 16'hAB34);
        wr(0, 4'd3, 16'h1111, 2'b11);
        wr(0, 4'd3, 16'h22CD, 2'b01);
        rd(0, 4'd3, 16'h11CD);
        repeat (3) step();
        chk("do_hold", dout[0], 16'h11CD);
        chk("do_valid_idle", dvld[0], 0);

        // LATENCY=2: ignored write left addr 0 cleared; back-to-back reads
        rd(2, 4'd0, 16'h0000);
        wr(2, 4'd0, 16'd10, 2'b11);
        wr(2, 4'd1, 16'd11, 2'b11);
        wr(2, 4'd2, 16'd12, 2'b11);
        rd(2, 4'd0, 16'd10);
        rd(2, 4'd1, 16'd11);
        rd(2, 4'd2, 16'd12);
        repeat (4) step();

        // LATENCY=3 full write / read
        wr(1, 4'd5, 16'hBEEF, 2'b11);
        rd(1, 4'd5, 16'hBEEF);
        repeat (5) step();
        chk("lat3_hold", dout[1], 16'hBEEF);

        // LATENCY=4: reset with a read in flight, then mid-clear reset
        wr(3, 4'd6, 16'h7777, 2'b11);
        rd(3, 4'd6, 16'h7777);
        repeat (6) step();
        chk("lat4_before_rst", dout[3], 16'h7777);
        en[3] = 1'b1; we[3] = 1'b0; a[3] = 4'd6;
        step();
        en[3] = 1'b0;
        rst[3] = 1'b1;
        step();
        chk("inflight_rst_do", dout[3], 0);
        chk("inflight_rst_ready", ready[3], 0);
        step();
        rst[3] = 1'b0;
        repeat (5) step();
        chk("midclear_ready", ready[3], 0);
        rst[3] = 1'b1;
        step();
        rst[3] = 1'b0;
        count_clear(3, "clear_restart_len");
        rd(3, 4'd6, 16'h0000);
        repeat (6) step();

        // no fill: contents survive reset, READY immediately
        wr(4, 4'd7, 16'h5A5A, 2'b11);
        rd(4, 4'd7, 16'h5A5A);
        repeat (2) step();
        rst[4] = 1'b1;
        step();
        chk("nofill_rst_do", dout[4], 0);
        rst[4] = 1'b0;
        chk("nofill_ready_after", ready[4], 1);
        rd(4, 4'd7, 16'h5A5A);
        repeat (3) step();

        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rrspsram_lat_be.md
RRSPSRAM_LAT_BE -- requirements
Module: rrspsram_lat_be

Interface
REQ-001 Parameter ADDR_WIDTH SHALL be: default 16; address width, DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH SHALL be: default 16; word width.
REQ-003 Parameter BYTE_WIDTH SHALL be: default 8; write-enable granule; DATA_WIDTH not a multiple of it is an elaboration error.
REQ-004 Parameter LATENCY SHALL be: default 1; read latency in cycles, legal range 1..4, else elaboration error.
REQ-005 Parameter CLEAR_ON_RESET SHALL be: default 1; 1 = zero-fill memory after reset, 0 = no fill.
REQ-006 Port CLK SHALL be: input, 1 bit; sole clock, all state on posedge.
REQ-007 Port RST SHALL be: input, 1 bit; synchronous, active-high reset.
REQ-008 Port A SHALL be: input, ADDR_WIDTH bits; word address.
REQ-009 Port DI SHALL be: input, DATA_WIDTH bits; write data.
REQ-010 Port BE SHALL be: input, DATA_WIDTH/BYTE_WIDTH bits; per-granule write enable, bit i covers DI[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-011 Port ENABLE SHALL be: input, 1 bit; request strobe.
REQ-012 Port WE SHALL be: input, 1 bit; 1 = write, 0 = read.
REQ-013 Port READY SHALL be: output, 1 bit; high when requests are accepted.
REQ-014 Port DO SHALL be: output, DATA_WIDTH bits; registered read data.
REQ-015 Port DO_VALID SHALL be: output, 1 bit; one-cycle pulse marking new data on DO.

Function
REQ-016 The controller SHALL have two states, CLEAR and RUN; READY = (state == RUN).
REQ-017 In CLEAR, a counter starting at 0 SHALL write all-zero to mem[counter] each cycle and increment; the cycle it writes DEPTH-1 SHALL move state to RUN, so READY rises exactly DEPTH cycles after RST deasserts.
REQ-018 A request SHALL be accepted only when ENABLE=1 and READY=1; ENABLE while READY=0 is ignored with no memory or output effect.
REQ-019 An accepted write SHALL update only granules whose BE bit is 1; BE all-zero is a no-op; no read is issued and DO/DO_VALID are unaffected.
REQ-020 An accepted read at cycle N SHALL present mem[A] on DO and pulse DO_VALID=1 at cycle N+LATENCY; back-to-back reads SHALL give one result per cycle, in order.
REQ-021 DO SHALL hold its last value when no read result completes; DO_VALID SHALL be 0 in those cycles.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the newly written granules merged with unchanged old granules.
REQ-023 Address SHALL be used unmodified; there is no wrap-around or out-of-range case, since DEPTH = 2**ADDR_WIDTH.

Reset
REQ-024 While RST=1, state SHALL be CLEAR if CLEAR_ON_RESET=1, else RUN; the clear counter SHALL be 0; DO SHALL be 0; DO_VALID and all read-pipeline valid bits SHALL be 0.
REQ-025 RST asserted mid-clear SHALL restart the clear from address 0.
REQ-026 RST asserted with reads in flight SHALL discard them; no DO_VALID pulse for them SHALL appear after reset.
REQ-027 With CLEAR_ON_RESET=0, memory contents SHALL be preserved across reset and READY SHALL be 1 on the first cycle after RST deasserts.

Structure
REQ-028 The state enum (CLEAR, RUN) and the LATENCY bounds (1, 4) SHALL live in a shared package, rrspsram_pkg.
REQ-029 The read-latency shift register (data plus valid, LATENCY-1 stages after the array register, reset-clearable valid bits) SHALL be one sub-module, sram_rd_pipe.
REQ-030 Memory SHALL be a single-port array of DEPTH words of DATA_WIDTH bits; the clear writes SHALL use the same port as normal writes.

Verification
REQ-031 Test: ADDR_WIDTH=4, CLEAR_ON_RESET=1; RST for 2 cycles -> READY=0 for exactly 16 cycles, then 1; reads of all 16 addresses return 0.
REQ-032 Test: LATENCY=3; write 16'hBEEF to addr 5 with BE=2'b11, then read addr 5 at cycle N -> DO=16'hBEEF, DO_VALID=1 at N+3 only.
REQ-033 Test: addr 2 holds 16'h1234; write DI=16'hAB00, BE=2'b10; read next cycle -> DO=16'hAB34. Then write with BE=2'b00 -> readback still 16'hAB34.
REQ-034 Test: LATENCY=2; reads of addr 0,1,2 on consecutive cycles holding 10,11,12 -> DO=10,11,12 on three consecutive cycles, with DO_VALID high for all three.
REQ-035 Test: assert RST one cycle after a read is issued with LATENCY=4 -> no DO_VALID pulse; DO=0; clear restarts at counter 0.
REQ-036 Test: CLEAR_ON_RESET=0; write 16'h5A5A to addr 7, pulse RST -> READY=1 on the first cycle after reset; read addr 7 returns 16'h5A5A.
